// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the iterative binary32 divider.
package fp32_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        ROUND,
        DONE
    } divStateT;

    localparam int          BIAS   = 127;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam int          N_ITER = 26;
    localparam int          REM_W  = 27;
    localparam int          EXP_W  = 10;

endpackage

// File: rtl/div_step_nr.sv
// One non-restoring division step over the signed partial remainder.
// With forceSub set the remainder is not doubled and mb is always subtracted,
// which turns the same cell into the initial R0 = ma - mb load.
module div_step_nr
    import fp32_div_pkg::*;
(
    input  logic [REM_W-1:0] R_prev,
    input  logic [23:0]      mb,
    input  logic             forceSub,
    output logic [REM_W-1:0] R_next,
    output logic             qbit
);

    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] mbExt;

    // Shift-then-add/subtract selected by the sign of the previous remainder.
    always_comb begin
        mbExt   = {{(REM_W-24){1'b0}}, mb};
        shifted = forceSub ? R_prev : {R_prev[REM_W-2:0], 1'b0};
        if (forceSub || !R_prev[REM_W-1]) begin
            R_next = shifted - mbExt;
        end else begin
            R_next = shifted + mbExt;
        end
        qbit = ~R_next[REM_W-1];
    end

endmodule

// File: rtl/fp32_div_iter.sv
// Sequential binary32 divider: special-case decode, 26 non-restoring quotient
// bits (one per clock), then RNE rounding and packing with a start/done handshake.
module fp32_div_iter
    import fp32_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic        invalid,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [EXP_W-1:0] EXP_OFF = EXP_W'(BIAS - 1);

    divStateT         state, stateNext;
    logic [4:0]       iterCount;
    logic [23:0]      maReg, mbReg;
    logic             signReg;
    logic [EXP_W-1:0] eBase;
    logic [REM_W-1:0] remReg;
    logic [25:0]      quoReg;

    logic [7:0]       expA, expB;
    logic             aZero, bZero, aInf, bInf, aNan, bNan, signIn;
    logic             specHit, specInv, specDbz;
    logic [31:0]      specQ;

    logic [REM_W-1:0] stepPrev, stepNext;
    logic [23:0]      stepMb;
    logic             stepForce, stepQbit;

    logic [REM_W-1:0] remFix;
    logic             remNz, guardBit, stickyBit, roundUp;
    logic [23:0]      mant, mantRnd;
    logic [24:0]      mantSum;
    logic [EXP_W-1:0] eNorm, eRnd;
    logic [31:0]      roundQ;
    logic             roundOvf, roundUnf;

    // Classify the incoming operands; denormals count as zero.
    always_comb begin
        expA   = a[30:23];
        expB   = b[30:23];
        signIn = a[31] ^ b[31];
        aZero  = (expA == 8'h00);
        bZero  = (expB == 8'h00);
        aInf   = (expA == 8'hFF) && (a[22:0] == 23'd0);
        bInf   = (expB == 8'hFF) && (b[22:0] == 23'd0);
        aNan   = (expA == 8'hFF) && (a[22:0] != 23'd0);
        bNan   = (expB == 8'hFF) && (b[22:0] != 23'd0);
    end

    // Resolve special operand combinations in priority order.
    always_comb begin
        specHit = 1'b1;
        specQ   = 32'd0;
        specInv = 1'b0;
        specDbz = 1'b0;
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            specQ   = QNAN;
            specInv = 1'b1;
        end else if (bZero && !aInf) begin
            specQ   = {signIn, 8'hFF, 23'd0};
            specDbz = 1'b1;
        end else if (aInf) begin
            specQ   = {signIn, 8'hFF, 23'd0};
        end else if (bInf || aZero) begin
            specQ   = {signIn, 31'd0};
        end else begin
            specHit = 1'b0;
        end
    end

    // The step cell computes R0 from the raw operands in IDLE and R_i otherwise.
    always_comb begin
        stepForce = (state == IDLE);
        stepPrev  = stepForce ? {{(REM_W-24){1'b0}}, 1'b1, a[22:0]} : remReg;
        stepMb    = stepForce ? {1'b1, b[22:0]} : mbReg;
    end

    div_step_nr uStep (
        .R_prev   (stepPrev),
        .mb       (stepMb),
        .forceSub (stepForce),
        .R_next   (stepNext),
        .qbit     (stepQbit)
    );

    // Normalize the 26-bit quotient, round to nearest even and pack.
    always_comb begin
        remFix = remReg[REM_W-1] ? remReg + {{(REM_W-24){1'b0}}, mbReg} : remReg;
        remNz  = |remFix;
        if (quoReg[25]) begin
            mant      = quoReg[25:2];
            guardBit  = quoReg[1];
            stickyBit = quoReg[0] | remNz;
            eNorm     = eBase + EXP_W'(1);
        end else begin
            mant      = quoReg[24:1];
            guardBit  = quoReg[0];
            stickyBit = remNz;
            eNorm     = eBase;
        end
        roundUp = guardBit & (stickyBit | mant[0]);
        mantSum = {1'b0, mant} + {24'd0, roundUp};
        if (mantSum[24]) begin
            mantRnd = 24'h80_0000;
            eRnd    = eNorm + EXP_W'(1);
        end else begin
            mantRnd = mantSum[23:0];
            eRnd    = eNorm;
        end
        roundOvf = ($signed(eRnd) >= $signed(EXP_W'(255)));
        roundUnf = ($signed(eRnd) <= $signed(EXP_W'(0)));
        if (roundOvf) begin
            roundQ = {signReg, 8'hFF, 23'd0};
        end else if (roundUnf) begin
            roundQ = {signReg, 31'd0};
        end else begin
            roundQ = {signReg, eRnd[7:0], mantRnd[22:0]};
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = specHit ? DONE : ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (iterCount == 5'(N_ITER - 1)) begin
                    stateNext = ROUND;
                end
            end
            ROUND: begin
                busy      = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, datapath registers and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            iterCount   <= '0;
            maReg       <= '0;
            mbReg       <= '0;
            signReg     <= 1'b0;
            eBase       <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            q           <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        signReg     <= signIn;
                        maReg       <= {1'b1, a[22:0]};
                        mbReg       <= {1'b1, b[22:0]};
                        eBase       <= {2'b00, expA} - {2'b00, expB} + EXP_OFF;
                        remReg      <= stepNext;
                        quoReg      <= {25'd0, stepQbit};
                        iterCount   <= 5'd1;
                        invalid     <= specHit & specInv;
                        div_by_zero <= specHit & specDbz;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        if (specHit) begin
                            q <= specQ;
                        end
                    end
                end
                ITER: begin
                    remReg    <= stepNext;
                    quoReg    <= {quoReg[24:0], stepQbit};
                    iterCount <= iterCount + 5'd1;
                end
                ROUND: begin
                    q         <= roundQ;
                    overflow  <= roundOvf;
                    underflow <= roundUnf;
                end
                default: ;
            endcase
        end
    end

endmodule
